sm_mem_arbiter: RTL and testbench
=================================

Name: sm_mem_arbiter

Overview:
- Shares one single-port 32-bit memory between two requesters: M0, the CPU port (fetch/read-only), and M1, the debug/loader port (read/write).
- Sits between sm_cpu's imAddr/imData and the memory, so a loader can fill program memory and a debugger can inspect it while the core runs.
- Arbitration: round-robin per cycle. M1 can lock the memory for bursts. A starvation counter guarantees M0 progress.

Parameters:
- ADDR_W, 6, word address width.
- WAIT_MAX, 8, maximum consecutive cycles M0 may request without a grant before it is forced a grant (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  M0 read request
- m0_addr  in  ADDR_W  M0 word address
- m0_gnt  out  1  M0 request accepted this cycle
- m0_rvalid  out  1  M0 read data valid
- m0_rdata  out  32  M0 read data
- m1_req  in  1  M1 request
- m1_we  in  1  M1 write (1) / read (0)
- m1_lock  in  1  M1 holds memory after its grant
- m1_addr  in  ADDR_W  M1 word address
- m1_wdata  in  32  M1 write data
- m1_gnt  out  1  M1 request accepted this cycle
- m1_rvalid  out  1  M1 read data valid
- m1_rdata  out  32  M1 read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, last=1 (so M0 wins the first conflict), wait_cnt=0, rd_pend=0. m0_rvalid and m1_rvalid are 0. Grants and mem_en are 0 whenever no request is asserted.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - gnt is combinational in the accepting cycle.
  - At most one grant per cycle; mem_* are driven from the granted requester in that same cycle.
  - No grant means mem_en=0, and mem_addr and mem_wdata hold their previous values (registered mux select).
- Read latency:
  - A read granted in cycle N gives owner rvalid=1 in N+1, with owner rdata=mem_rdata.
  - The non-owner's rdata is 0.
  - A write produces no rvalid.
  - Back-to-back reads from alternating requesters are supported, one per cycle.
- States:
  - IDLE (round-robin):
    - Only one requester asserting: that one is granted.
    - Both asserting: the one with last != own index is granted.
    - last updates to the granted index.
    - An M1 grant with m1_lock=1 goes to LOCK.
  - LOCK:
    - M1 is granted whenever m1_req=1; M0 is blocked.
    - m1_lock=0 in any cycle returns the block to IDLE next cycle; a request in that same cycle is still arbitrated as LOCK.
    - m1_req=0 with m1_lock=1 stays in LOCK with no grant.
- Starvation counter:
  - wait_cnt increments each cycle that m0_req=1 and m0_gnt=0, saturating at WAIT_MAX.
  - It clears on an M0 grant or when m0_req=0.
  - When wait_cnt==WAIT_MAX, M0 is granted that cycle in any state, overriding lock and round-robin. The state is unchanged, so LOCK resumes the next cycle.
- Address/width: addresses pass through unmodified; there is no range checking.
- Reset mid-operation: a pending rvalid is dropped (rvalid=0 after reset). A memory write already strobed is not undone.

Optional Feature:
- SM_ARB_FIXED_PRIO_EN defined:
  - IDLE uses fixed priority M1 > M0 instead of round-robin, and last is unused.
  - The starvation override remains active, so M0 is still guaranteed a grant within WAIT_MAX+1 cycles.
- Not defined: round-robin as described.

Test Plan:
- Reset with both requesting (m0_addr=3, m1_addr=5, m1_we=0) -> cycle 0: m0_gnt=1, mem_addr=3. Cycle 1: m1_gnt=1, mem_addr=5, m0_rvalid=1 with mem data. Cycle 2: m1_rvalid=1.
- M1 writes 0xDEADBEEF to address 10, then M0 reads 10 -> mem_we=1 for one cycle; the M0 read returns m0_rdata=0xDEADBEEF one cycle after its grant. m1_rvalid never asserts.
- M1 holds lock with continuous writes and M0 requests continuously, WAIT_MAX=8 -> M0 is denied for 8 cycles. Cycle 9: m0_gnt=1, m1_gnt=0. Then the M1 writes resume; wait_cnt=0.
- In LOCK with m1_req=0 and m1_lock=1, m0_req=1 -> no grants and mem_en=0 until forced. Drop m1_lock -> M0 is granted the next cycle.
- Assert rst_n=0 asynchronously the cycle after an M0 read grant -> m0_rvalid=0 immediately; state returns to IDLE.
- With SM_ARB_FIXED_PRIO_EN, both requesting continuously, unlocked -> M1 is granted every cycle except one M0 grant in every WAIT_MAX+1 cycles.

Source files
------------

// File: rtl/sm_mem_arbiter.sv
// sm_mem_arbiter: shares one single-port memory between a CPU fetch port (M0) and a debug/loader port (M1).
// Optional macro SM_ARB_FIXED_PRIO_EN: fixed M1 > M0 priority in IDLE instead of round-robin.
module sm_mem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t            state;
    logic              last;
    logic              rd0;
    logic              rd1;
    logic              force_m0;
    logic [7:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    assign force_m0 = m0_req && (wait_cnt == 8'(WAIT_MAX));
    // The starvation override beats both the lock and the normal arbitration.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (force_m0)
            m0_gnt = 1'b1;
        else if (state == LOCK)
            m1_gnt = m1_req;
`ifdef SM_ARB_FIXED_PRIO_EN
        else begin
            m1_gnt = m1_req;
            m0_gnt = m0_req && !m1_req;
        end
`else
        else begin
            m0_gnt = m0_req && (!m1_req || last);
            m1_gnt = m1_req && !(m0_req && (!m1_req || last));
        end
`endif
    end
    assign mem_en    = m0_gnt || m1_gnt;
    assign mem_we    = m1_gnt && m1_we;
    assign mem_addr  = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : addr_q);
    assign mem_wdata = m1_gnt ? m1_wdata : wdata_q;
    assign m0_rvalid = rd0;
    assign m1_rvalid = rd1;
    assign m0_rdata  = rd0 ? mem_rdata : 32'd0;
    assign m1_rdata  = rd1 ? mem_rdata : 32'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            wait_cnt <= 8'd0;
            rd0      <= 1'b0;
            rd1      <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
        end else begin
            if (state == LOCK)
                state <= m1_lock ? LOCK : IDLE;
            else if (m1_gnt && m1_lock)
                state <= LOCK;
            if (mem_en)
                last <= m1_gnt;
            wait_cnt <= (!m0_req || m0_gnt) ? 8'd0 :
                        (force_m0 ? wait_cnt : wait_cnt + 8'd1);
            rd0     <= m0_gnt;
            rd1     <= m1_gnt && !m1_we;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb_sm_mem_arbiter: directed stimulus with a per-cycle reference model and hand-computed literal checks.
module tb_sm_mem_arbiter;
    localparam int ADDR_W   = 6;
    localparam int WAIT_MAX = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [31:0]       m0_rdata;
    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [31:0]       m1_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int errors = 0;
    int checks = 0;

    sm_mem_arbiter #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous single-port RAM with one-cycle read latency.
    logic [31:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + i;
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks who is owed what and what the memory must contain.
    bit          md_locked;
    bit          md_m1_last;
    int          md_waited;
    bit          md_pend0, md_pend1;
    logic [31:0] md_data;
    logic [ADDR_W-1:0] md_addr;
    logic [31:0] md_wdata;
    logic [31:0] shadow [64];
    initial for (int i = 0; i < 64; i++) shadow[i] = 32'hA000_0000 + i;

    always @(negedge clk) begin
        bit e0, e1;
        logic [ADDR_W-1:0] ea;
        logic [31:0] ew;
        if (!rst_n) begin
            md_locked = 0; md_m1_last = 1; md_waited = 0;
            md_pend0 = 0; md_pend1 = 0; md_addr = '0; md_wdata = '0;
        end
        e0 = 0; e1 = 0;
        if (m0_req && md_waited >= WAIT_MAX) e0 = 1;
        else if (md_locked) e1 = m1_req;
`ifdef SM_ARB_FIXED_PRIO_EN
        else if (m1_req) e1 = 1;
        else e0 = m0_req;
`else
        else if (m0_req && m1_req) begin e0 = md_m1_last; e1 = !md_m1_last; end
        else begin e0 = m0_req; e1 = m1_req; end
`endif
        ea = e0 ? m0_addr : (e1 ? m1_addr : md_addr);
        ew = e1 ? m1_wdata : md_wdata;
        chk("m0_gnt", 32'(m0_gnt), 32'(e0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e1));
        chk("mem_en", 32'(mem_en), 32'(e0 | e1));
        chk("mem_we", 32'(mem_we), 32'(e1 && m1_we));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", mem_wdata, ew);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(md_pend0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(md_pend1));
        chk("m0_rdata", m0_rdata, md_pend0 ? md_data : 32'd0);
        chk("m1_rdata", m1_rdata, md_pend1 ? md_data : 32'd0);
        if (rst_n) begin
            md_pend0 = e0;
            md_pend1 = e1 && !m1_we;
            md_data  = shadow[ea];
            if (e1 && m1_we) shadow[m1_addr] = m1_wdata;
            if (e0 || e1) md_m1_last = e1;
            md_waited = (!m0_req || e0) ? 0 : md_waited + 1;
            if (md_locked) md_locked = m1_lock;
            else if (e1 && m1_lock) md_locked = 1;
            md_addr  = ea;
            md_wdata = ew;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gnt_at, n0, n1;
        bit s0, s1;
        rst_n = 1'b0;
        m0_req = 1; m0_addr = 3;
        m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 5; m1_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Both requesting out of reset: M0 first, then M1, reads return in order.
        @(negedge clk);
        chk("t1_c0_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("t1_c0_addr", 32'(mem_addr), 32'd3);
        step(); m0_req = 0;
        @(negedge clk);
        chk("t1_c1_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("t1_c1_addr", 32'(mem_addr), 32'd5);
        chk("t1_c1_m0_rdata", m0_rdata, 32'hA000_0003);
        step(); m1_req = 0;
        @(negedge clk);
        chk("t1_c2_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("t1_c2_m1_rdata", m1_rdata, 32'hA000_0005);

        // M1 write then M0 read-back.
        step(); m1_req = 1; m1_we = 1; m1_addr = 10; m1_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_write_we", 32'(mem_we), 32'd1);
        step(); m1_req = 0; m1_we = 0; m0_req = 1; m0_addr = 10;
        @(negedge clk);
        chk("t2_read_gnt", 32'(m0_gnt), 32'd1);
        chk("t2_no_we", 32'(mem_we), 32'd0);
        step(); m0_req = 0;
        @(negedge clk);
        chk("t2_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t2_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // Locked M1 write burst starves M0 until the guard forces a grant.
        step(); m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 20; m1_wdata = 32'h1234_5678;
        m0_req = 1; m0_addr = 4;
        gnt_at = 0;
        for (int c = 1; c <= 20 && gnt_at == 0; c++) begin
            @(negedge clk);
            if (m0_gnt) begin
                gnt_at = c;
                chk("t3_forced_m1_gnt", 32'(m1_gnt), 32'd0);
            end
            step();
        end
        chk("t3_forced_cycle", 32'(gnt_at), 32'd9);
        m0_req = 0;
        @(negedge clk);
        chk("t3_lock_resumes", 32'(m1_gnt), 32'd1);

        // Idle lock: nothing granted, then M0 gets in the cycle after lock drops.
        step(); m1_req = 0; m1_we = 0; m0_req = 1; m0_addr = 6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_idle_lock_en", 32'(mem_en), 32'd0);
            step();
        end
        m1_lock = 0;
        @(negedge clk);
        chk("t4_drop_cycle_gnt", 32'(m0_gnt), 32'd0);
        step();
        @(negedge clk);
        chk("t4_after_drop_gnt", 32'(m0_gnt), 32'd1);
        step(); m0_req = 0;

        // Async reset while a read is in flight drops rvalid at once.
        m0_req = 1; m0_addr = 7;
        @(negedge clk);
        chk("t5_gnt", 32'(m0_gnt), 32'd1);
        step(); m0_req = 0;
        chk("t5_rvalid_before", 32'(m0_rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("t5_rvalid_reset", 32'(m0_rvalid), 32'd0);
        step();
        rst_n = 1'b1;

        // Alternating back-to-back reads from both ports.
        m0_req = 1; m0_addr = 0; m1_req = 1; m1_we = 0; m1_addr = 32;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s0 = m0_gnt; s1 = m1_gnt;
            step();
            if (s0) begin n0++; m0_addr = m0_addr + 1; end
            if (s1) begin n1++; m1_addr = m1_addr + 1; end
        end
        chk("t6_m0_grants", 32'(n0), 32'd5);
        chk("t6_m1_grants", 32'(n1), 32'd5);
        m0_req = 0; m1_req = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
